// File: rtl/alu_exec_unit.sv
// EX-stage ALU with valid/ready in and out; shifts iterate one bit per cycle.
// Result, zero and illegal are registered and held until the next result.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         operation,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1011;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic [SHAMT_W-1:0] r_cnt;
    logic [1:0]         r_sop;
    logic               r_zero;
    logic               r_illegal;

    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_imm;
    logic [WIDTH-1:0]   w_step;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_legal;
    logic               w_is_shift;
    logic               w_accept;
    logic               w_iter;
    logic               w_last;

    assign w_shamt  = b[SHAMT_W-1:0];
    assign w_accept = in_valid & in_ready;
    assign w_iter   = w_is_shift & (w_shamt != '0);
    assign w_imm    = w_is_shift ? a : w_alu;
    assign w_last   = (r_cnt == SHAMT_W'(1));

    always_comb begin
        w_alu      = '0;
        w_legal    = 1'b1;
        w_is_shift = 1'b0;
        case (operation)
            OP_AND: w_alu = a & b;
            OP_OR:  w_alu = a | b;
            OP_ADD: w_alu = a + b;
            OP_SUB: w_alu = a - b;
            OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_XOR: w_alu = a ^ b;
            OP_SLL, OP_SRL, OP_SRA: w_is_shift = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    // r_sop holds operation[1:0]: 00 SLL, 01 SRL, 11 SRA
    always_comb begin
        case (r_sop)
            2'b00:   w_step = r_acc << 1;
            2'b01:   w_step = r_acc >> 1;
            default: w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_iter ? S_SHIFT : S_HOLD;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sop     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (r_state == S_IDLE && w_accept) begin
            if (w_iter) begin
                r_acc <= a;
                r_cnt <= w_shamt;
                r_sop <= operation[1:0];
            end else begin
                r_result  <= w_imm;
                r_zero    <= (w_imm == '0);
                r_illegal <= ~w_legal;
            end
        end else if (r_state == S_SHIFT) begin
            r_acc <= w_step;
            r_cnt <= r_cnt - SHAMT_W'(1);
            if (w_last) begin
                r_result  <= w_step;
                r_zero    <= (w_step == '0);
                r_illegal <= 1'b0;
            end
        end
    end

    assign result  = r_result;
    assign zero    = r_zero;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reference model plus scoreboard,
// with literal expectations on the spec's corner vectors.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          acc;
        int          due;
        bit          has_lit;
        logic [31:0] lit;
        int          lit_lat;
    } ent_t;

    ent_t q[$];
    ent_t e;
    bit   seen;
    int   cyc;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [3:0] op,
                                  input logic [31:0] av,
                                  input logic [31:0] bv,
                                  output logic [31:0] r,
                                  output logic ill,
                                  output int lat);
        logic signed [31:0] sa;
        int sh;
        sa  = av;
        sh  = int'(bv % 32);
        ill = 1'b0;
        lat = 1;
        case (op)
            4'b0000: r = av & bv;
            4'b0001: r = av | bv;
            4'b0010: r = av + bv;
            4'b0110: r = av - bv;
            4'b0111: r = (sa < $signed(bv)) ? 32'd1 : 32'd0;
            4'b1100: r = av ^ bv;
            4'b1000: begin r = av << sh; lat = 1 + sh; end
            4'b1001: begin r = av >> sh; lat = 1 + sh; end
            4'b1011: begin r = sa >>> sh; lat = 1 + sh; end
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    task automatic send(input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input bit lit_on,
                        input logic [31:0] lit, input int lit_lat);
        ent_t n;
        int   w;
        int   lat;
        @(negedge clk);
        in_valid  = 1'b1;
        operation = op;
        a         = av;
        b         = bv;
        w         = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        model(op, av, bv, n.res, n.ill, lat);
        n.acc     = cyc;
        n.due     = cyc + lat;
        n.has_lit = lit_on;
        n.lit     = lit;
        n.lit_lat = lit_lat;
        q.push_back(n);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operation = 4'b0010;
        a         = 32'hDEAD_BEEF;
        b         = 32'hFFFF_FFFF;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard: checks every cycle the result is presented.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            q.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = q[0];
                chk("result", result, e.res);
                chk("zero", {31'd0, zero}, {31'd0, e.res == 32'd0});
                chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                chk("in_ready_hold", {31'd0, in_ready}, 32'd0);
                if (!seen) begin
                    chk("latency", cyc, e.due);
                    if (e.has_lit) begin
                        chk("lit_result", result, e.lit);
                        chk("lit_latency", cyc - e.acc, e.lit_lat);
                    end
                    seen = 1'b1;
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end else if (q.size() != 0 && cyc > q[0].due) begin
            chk("valid_timeout", 32'd0, 32'd1);
            void'(q.pop_front());
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        seen      = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operation = 4'd0;
        a         = 32'd0;
        b         = 32'd0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        #20 rst_n = 1'b1;

        send(4'b0010, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1);
        send(4'b0110, 32'd0, 32'd1, 1, 32'hFFFF_FFFF, 1);
        send(4'b0111, 32'hFFFF_FFFE, 32'd3, 1, 32'd1, 1);
        send(4'b0111, 32'd3, 32'hFFFF_FFFE, 1, 32'd0, 1);
        send(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 1);
        send(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hFFF0_FFF0, 1);
        send(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FF0_0FF0, 1);
        drain();

        send(4'b1000, 32'd1, 32'd20, 0, 32'd0, 0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_result", result, 32'd0);
        #10 rst_n = 1'b1;
        send(4'b0010, 32'd7, 32'd9, 1, 32'd16, 1);

        send(4'b1011, 32'h8000_0000, 32'd31, 1, 32'hFFFF_FFFF, 32);
        send(4'b1001, 32'h8000_0000, 32'd31, 1, 32'h0000_0001, 32);
        send(4'b1000, 32'd1, 32'd0, 1, 32'd1, 1);
        send(4'b1000, 32'd3, 32'h25, 1, 32'h60, 6);
        send(4'b1011, 32'h7000_0000, 32'd4, 0, 32'd0, 0);
        drain();

        out_ready = 1'b0;
        send(4'b0010, 32'd10, 32'd20, 1, 32'd30, 1);
        fork
            send(4'b0001, 32'h0000_00F0, 32'h0000_000F, 1, 32'hFF, 1);
            begin
                @(negedge clk);
                repeat (10) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                    chk("bp_result", result, 32'd30);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        send(4'b0101, 32'd12, 32'd34, 1, 32'd0, 1);
        drain();
        chk("illegal_kept_idle", {31'd0, illegal}, 32'd1);
        send(4'b0010, 32'd2, 32'd3, 1, 32'd5, 1);
        drain();
        chk("illegal_cleared", {31'd0, illegal}, 32'd0);
        chk("held_result", result, 32'd5);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
